// File: rtl/video_timing_gen.sv
// Pixel-rate raster timing: h/v counters with registered blank/sync flags, de, frame_start.
// Define VTG_SCROLL_EN to build the per-frame scroll accumulator; otherwise scroll is tied to 0.
module video_timing_gen #(
   parameter int H_TOTAL       = 640,
   parameter int H_BLANK_START = 310,
   parameter int H_BLANK_END   = 420,
   parameter int H_SYNC_START  = 336,
   parameter int H_SYNC_END    = 368,
   parameter int V_TOTAL       = 312,
   parameter int V_BLANK_START = 306,
   parameter int V_BLANK_END   = 2,
   parameter int V_SYNC_START  = 308,
   parameter int V_SYNC_END    = 0,
   parameter int SCROLL_STEP   = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce_pix,
   output logic [9:0] hc,
   output logic [8:0] vc,
   output logic       hblank,
   output logic       hsync,
   output logic       vblank,
   output logic       vsync,
   output logic       de,
   output logic       frame_start,
   output logic [9:0] scroll
);

   if (H_TOTAL < 1 || H_TOTAL > 1024 || V_TOTAL < 1 || V_TOTAL > 512 ||
       H_BLANK_START < 0 || H_BLANK_START >= H_TOTAL || H_BLANK_END < 0 || H_BLANK_END >= H_TOTAL ||
       H_SYNC_START  < 0 || H_SYNC_START  >= H_TOTAL || H_SYNC_END  < 0 || H_SYNC_END  >= H_TOTAL ||
       V_BLANK_START < 0 || V_BLANK_START >= V_TOTAL || V_BLANK_END < 0 || V_BLANK_END >= V_TOTAL ||
       V_SYNC_START  < 0 || V_SYNC_START  >= V_TOTAL || V_SYNC_END  < 0 || V_SYNC_END  >= V_TOTAL ||
       SCROLL_STEP < 0 || SCROLL_STEP > 1023) begin : g_bad_params
      $error("video_timing_gen: raster parameter out of range");
   end

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
   localparam logic [9:0] HBS    = 10'(H_BLANK_START);
   localparam logic [9:0] HBE    = 10'(H_BLANK_END);
   localparam logic [9:0] HSS    = 10'(H_SYNC_START);
   localparam logic [9:0] HSE    = 10'(H_SYNC_END);
   localparam logic [8:0] VBS    = 9'(V_BLANK_START);
   localparam logic [8:0] VBE    = 9'(V_BLANK_END);
   localparam logic [8:0] VSS    = 9'(V_SYNC_START);
   localparam logic [8:0] VSE    = 9'(V_SYNC_END);

   logic h_wrap;
   logic v_wrap;
   logic frame_wrap;

   assign h_wrap     = (hc == H_LAST);
   assign v_wrap     = (vc == V_LAST);
   assign frame_wrap = ce_pix && h_wrap && v_wrap;
   assign de         = !hblank && !vblank;

   // NOTE: state registers use non-blocking assignments so every compare sees the pre-edge counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hc          <= '0;
         vc          <= '0;
         hblank      <= 1'b0;
         hsync       <= 1'b0;
         vblank      <= 1'b1;
         vsync       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_wrap;
         if (ce_pix) begin
            if (h_wrap) begin
               hc <= '0;
               vc <= v_wrap ? 9'd0 : vc + 9'd1;
            end else begin
               hc <= hc + 10'd1;
            end
            // Set is tested first so START==END leaves the flag stuck high.
            if (hc == HBS)      hblank <= 1'b1;
            else if (hc == HBE) hblank <= 1'b0;
            if (hc == HSS)      hsync  <= 1'b1;
            else if (hc == HSE) hsync  <= 1'b0;
            if (vc == VBS)      vblank <= 1'b1;
            else if (vc == VBE) vblank <= 1'b0;
            if (vc == VSS)      vsync  <= 1'b1;
            else if (vc == VSE) vsync  <= 1'b0;
         end
      end
   end

`ifdef VTG_SCROLL_EN
   localparam logic [9:0] SCROLL_INC = 10'(SCROLL_STEP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           scroll <= '0;
      else if (frame_wrap) scroll <= scroll + SCROLL_INC;
   end
`else
   assign scroll = 10'd0;
`endif

endmodule
